// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM states, key code layout and column priority helper.
package keypad_pkg;

   localparam int unsigned ROW_W = 2;
   localparam int unsigned COL_W = 2;
   localparam int unsigned COLS  = 1 << COL_W;

   typedef enum logic [1:0] {
      StScan,
      StDebounce,
      StAccept,
      StWaitRelease
   } scan_state_e;

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
   } key_code_t;

   // Lowest-numbered closed column wins when several are sensed at once.
   function automatic logic [COL_W-1:0] lowest_col(input logic [COLS-1:0] cols);
      lowest_col = '0;
      for (int i = COLS - 1; i >= 0; i--) begin
         if (cols[i]) lowest_col = COL_W'(i);
      end
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Row dwell counter: pulses tick on the last cycle of each SCAN_DIV-cycle dwell period.
module scan_tick_gen #(
   parameter int unsigned SCAN_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: walks rows, debounces presses and releases, and hands keys out through a
// valid/ready register with a sticky overrun flag.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 4,
   parameter int unsigned DEBOUNCE = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [COLS-1:0]  col_in,
   output logic [ROW_W-1:0] row_sel,
   output logic [3:0]       key_code,
   output logic             key_valid,
   input  logic             key_ready,
   output logic             key_held,
   output logic             overrun
);

   localparam logic [3:0] DEB = 4'(DEBOUNCE);

   scan_state_e state;
   key_code_t   capture;
   key_code_t   sample;
   logic [3:0]  match_cnt;
   logic [3:0]  rel_cnt;
   logic        tick;
   logic        col_hit;
   logic        sample_match;
   logic        accept_now;
   logic        handshake;

   scan_tick_gen #(
      .SCAN_DIV(SCAN_DIV)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .tick(tick)
   );

   always_comb begin
      sample       = '{row: row_sel, col: lowest_col(col_in)};
      col_hit      = |col_in;
      sample_match = col_hit && (sample == capture);
      handshake    = key_valid && key_ready;
      accept_now   = 1'b0;
      // Accept fires on the final matching tick so key_valid rises on the very next cycle.
      if (en && tick) begin
         if (state == StScan && col_hit && DEB == 4'd1) accept_now = 1'b1;
         if (state == StDebounce && sample_match && (match_cnt + 4'd1) == DEB) accept_now = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StScan;
         row_sel   <= '0;
         capture   <= '0;
         match_cnt <= '0;
         rel_cnt   <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (handshake) key_valid <= 1'b0;

         if (accept_now) begin
            if (!key_valid || key_ready) begin
               key_code  <= sample;
               key_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
            key_held <= 1'b1;
         end

         if (!en) begin
            state     <= StScan;
            row_sel   <= '0;
            match_cnt <= '0;
            rel_cnt   <= '0;
            key_held  <= 1'b0;
         end else if (tick || state == StAccept) begin
            case (state)
               StScan: begin
                  if (!col_hit) begin
                     row_sel <= row_sel + ROW_W'(1);
                  end else begin
                     capture   <= sample;
                     match_cnt <= accept_now ? 4'd0 : 4'd1;
                     state     <= accept_now ? StAccept : StDebounce;
                  end
               end
               StDebounce: begin
                  if (!sample_match) begin
                     state     <= StScan;
                     row_sel   <= row_sel + ROW_W'(1);
                     match_cnt <= '0;
                  end else if (accept_now) begin
                     state     <= StAccept;
                     match_cnt <= '0;
                  end else begin
                     match_cnt <= match_cnt + 4'd1;
                  end
               end
               StAccept: begin
                  state <= StWaitRelease;
               end
               StWaitRelease: begin
                  if (col_hit) begin
                     rel_cnt <= '0;
                  end else if ((rel_cnt + 4'd1) == DEB) begin
                     state    <= StScan;
                     row_sel  <= row_sel + ROW_W'(1);
                     rel_cnt  <= '0;
                     key_held <= 1'b0;
                  end else begin
                     rel_cnt <= rel_cnt + 4'd1;
                  end
               end
               default: state <= StScan;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a virtual keypad drives col_in from the scanned row, and a
// tick-level behavioural model predicts every output each cycle.
module tb_keypad_scan_ctrl;

   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned DEBOUNCE = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       key_ready = 1'b0;
   logic [3:0] col_in = '0;
   logic [1:0] row_sel;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic       overrun;

   keypad_scan_ctrl #(
      .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE(DEBOUNCE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .col_in   (col_in),
      .row_sel  (row_sel),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_ready(key_ready),
      .key_held (key_held),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Pressed keys per row: pad[r][c] = 1 means key (r,c) is closed.
   logic [3:0] pad [4];

   int m_dwell = 0, m_row = 0, m_streak = 0, m_cand = 0, m_rel = 0, m_code = 0;
   bit m_held = 1'b0, m_valid = 1'b0, m_ovr = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int first_col(input logic [3:0] m);
      for (int i = 0; i < 4; i++) begin
         if (m[i]) return i;
      end
      return -1;
   endfunction

   // Predicts the outputs after the coming clock edge from the current inputs.
   task automatic model_step();
      bit tick;
      bit next_valid;
      int col;
      if (rst) begin
         m_dwell = 0; m_row = 0; m_streak = 0; m_rel = 0; m_code = 0;
         m_held = 0; m_valid = 0; m_ovr = 0;
         return;
      end
      next_valid = m_valid && !key_ready;
      if (!en) begin
         m_dwell = 0; m_row = 0; m_streak = 0; m_rel = 0; m_held = 0;
      end else begin
         tick = (m_dwell == SCAN_DIV - 1);
         m_dwell = tick ? 0 : m_dwell + 1;
         if (tick) begin
            col = first_col(col_in);
            if (m_held) begin
               if (col < 0) begin
                  m_rel++;
                  if (m_rel == DEBOUNCE) begin
                     m_held = 0; m_rel = 0; m_row = (m_row + 1) % 4;
                  end
               end else begin
                  m_rel = 0;
               end
            end else if (col < 0 || (m_streak > 0 && col != m_cand)) begin
               m_streak = 0;
               m_row = (m_row + 1) % 4;
            end else begin
               m_cand = col;
               m_streak++;
               if (m_streak == DEBOUNCE) begin
                  m_streak = 0;
                  m_held = 1;
                  if (!m_valid || key_ready) begin
                     m_code = m_row * 4 + col;
                     next_valid = 1;
                  end else begin
                     m_ovr = 1;
                  end
               end
            end
         end
      end
      m_valid = next_valid;
   endtask

   task automatic cycle();
      col_in = pad[m_row];
      model_step();
      @(posedge clk);
      #1;
      check_val("row_sel", row_sel, m_row);
      check_val("key_valid", key_valid, m_valid);
      check_val("key_code", key_code, m_code);
      check_val("key_held", key_held, m_held);
      check_val("overrun", overrun, m_ovr);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_held(input bit want);
      for (int i = 0; i < 400 && m_held != want; i++) cycle();
      check_val("held_wait", key_held, want);
   endtask

   task automatic consume();
      key_ready = 1'b1;
      cycle();
      key_ready = 1'b0;
   endtask

   task automatic clear_pad();
      for (int r = 0; r < 4; r++) pad[r] = '0;
   endtask

   initial begin
      clear_pad();
      run(2);
      check_val("rst_row", row_sel, 0);
      check_val("rst_valid", key_valid, 0);
      check_val("rst_code", key_code, 0);
      check_val("rst_ovr", overrun, 0);

      // Idle scan: one row step every SCAN_DIV cycles.
      rst = 1'b0;
      en  = 1'b1;
      run(4);
      check_val("scan_step1", row_sel, 1);
      run(12);
      check_val("scan_wrap", row_sel, 0);
      check_val("scan_novalid", key_valid, 0);

      // Key at row 2, column 1.
      pad[2] = 4'b0010;
      wait_held(1'b1);
      check_val("r2c1_code", key_code, 4'h9);
      check_val("r2c1_valid", key_valid, 1);
      pad[2] = '0;
      wait_held(1'b0);
      check_val("resume_row3", row_sel, 3);
      consume();

      // Bounce: only two matching ticks on row 1.
      pad[1] = 4'b0001;
      for (int i = 0; i < 400 && m_streak != 2; i++) cycle();
      pad[1] = '0;
      for (int i = 0; i < 40 && m_row == 1; i++) cycle();
      check_val("bounce_row", row_sel, 2);
      check_val("bounce_valid", key_valid, 0);

      // Multiple columns: lowest wins.
      pad[0] = 4'b1010;
      wait_held(1'b1);
      check_val("low_col_code", key_code, 4'h1);
      pad[0] = '0;
      wait_held(1'b0);
      consume();

      // Second key while the first is unconsumed.
      pad[1] = 4'b0001;
      wait_held(1'b1);
      check_val("first_code", key_code, 4'h4);
      pad[1] = '0;
      wait_held(1'b0);
      pad[3] = 4'b1000;
      wait_held(1'b1);
      check_val("ovr_code", key_code, 4'h4);
      check_val("ovr_flag", overrun, 1);
      pad[3] = '0;
      wait_held(1'b0);
      consume();
      check_val("consumed", key_valid, 0);

      // Reset while a key is held, then re-detect.
      pad[2] = 4'b0100;
      wait_held(1'b1);
      rst = 1'b1;
      cycle();
      check_val("mid_rst_held", key_held, 0);
      check_val("mid_rst_valid", key_valid, 0);
      check_val("mid_rst_ovr", overrun, 0);
      check_val("mid_rst_row", row_sel, 0);
      rst = 1'b0;
      wait_held(1'b1);
      check_val("redetect_code", key_code, 4'hA);
      pad[2] = '0;
      wait_held(1'b0);

      // Random presses, bounces, ready, enable and reset activity.
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 59) == 0) clear_pad();
         if ($urandom_range(0, 59) == 0) begin
            clear_pad();
            pad[$urandom_range(0, 3)] = 4'($urandom_range(1, 15));
         end
         key_ready = ($urandom_range(0, 2) == 0);
         en  = ($urandom_range(0, 149) != 0);
         rst = ($urandom_range(0, 799) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SCAN_DIV, 4, clock cycles each row is driven before col_in is sampled; legal range 2..65535.
REQ-002 DEBOUNCE, 3, consecutive identical samples required to accept a press or a release; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  scan enable.
REQ-006 col_in  input  4  keypad column sense, active-high (1 = key closed), already synchronised externally.
REQ-007 row_sel  output  2  binary row index, driving the 2-to-4 row decoder.
REQ-008 key_code  output  4  accepted key, {row[1:0], col[1:0]}.
REQ-009 key_valid  output  1  key_code holds an unconsumed key.
REQ-010 key_ready  input  1  consumer accepts key_code.
REQ-011 key_held  output  1  accepted key is still pressed.
REQ-012 overrun  output  1  sticky flag: a key was dropped because key_valid was still pending.

Function
REQ-013 A dwell counter SHALL count 0..SCAN_DIV-1 while en=1; a "tick" is the cycle where it equals SCAN_DIV-1; col_in is sampled only on ticks.
REQ-014 FSM states SHALL be SCAN, DEBOUNCE, ACCEPT, WAIT_RELEASE.
REQ-015 SCAN: on a tick with col_in==0, row_sel SHALL advance by 1 (3 wraps to 0); on a tick with col_in!=0, capture row=row_sel, col=lowest set bit index, set match count to 1, go DEBOUNCE, row_sel frozen.
REQ-016 DEBOUNCE: on each tick, if the sampled {row,col} equals the capture, increment match count; when it reaches DEBOUNCE, go ACCEPT. If it differs or col_in==0, go SCAN and advance row_sel.
REQ-017 With DEBOUNCE=1, the detecting SCAN tick SHALL go directly to ACCEPT.
REQ-018 ACCEPT (one cycle): if key_valid=0, load key_code and set key_valid; else keep key_code and set overrun; then go WAIT_RELEASE.
REQ-019 WAIT_RELEASE: key_held=1, row_sel frozen; release counter counts consecutive ticks with col_in==0 and clears on any nonzero tick; at DEBOUNCE, go SCAN and advance row_sel.
REQ-020 key_valid SHALL clear in the cycle after a cycle with key_valid=1 and key_ready=1; if ACCEPT coincides with that handshake, the new key is loaded, key_valid stays 1, no overrun.
REQ-021 key_code SHALL be stable while key_valid=1.
REQ-022 en=0 SHALL force state SCAN, row_sel 0, and dwell/match/release counters 0, and SHALL clear key_held; key_valid, key_code and overrun are unaffected and the handshake still operates.
REQ-023 Latency: key_valid SHALL rise exactly 1 cycle after the DEBOUNCE-th matching tick.
REQ-024 overrun SHALL clear only on reset.

Reset
REQ-025 On rst=1 at a clock edge: state SCAN, row_sel 0, key_code 0, key_valid 0, key_held 0, overrun 0, all counters 0; rst overrides en and key_ready.
REQ-026 Reset asserted mid-debounce or mid-release SHALL discard the capture; no key_valid for that press.

Structure
REQ-027 Package keypad_pkg SHALL hold the FSM state enum, ROW_W=2, COL_W=2, and the key_code field layout.
REQ-028 The dwell counter SHALL be sub-module scan_tick_gen (inputs clk, rst, en; output tick), parameterised by SCAN_DIV.

Verification (SCAN_DIV=4, DEBOUNCE=3)
REQ-029 Reset then en=1, col_in=0: row_sel steps 0,1,2,3,0 every 4 cycles; key_valid stays 0.
REQ-030 col_in=4'b0010 while row_sel=2 and for 3 ticks: key_code=4'h9, key_valid 1 cycle after 3rd tick, key_held=1; release for 3 ticks -> key_held=0 and scan resumes at row 3.
REQ-031 Bounce: col_in nonzero on 2 ticks, then 0: no key_valid, scan resumes at next row.
REQ-032 col_in=4'b1010 on row 0: key_code=4'h1 (lowest column wins).
REQ-033 key_ready=0, two keys pressed and released in turn (row1 col0, then row3 col3): key_code stays 4'h4, overrun=1; key_ready=1 for one cycle -> key_valid=0 on the next cycle.
REQ-034 Assert rst during WAIT_RELEASE with key held: all outputs 0 the next cycle; the key is re-detected and re-debounced after rst deasserts.
